ikaopll_phase_capture: RTL and testbench

Debug reader for the phase generator's per-slot phase output. It tracks the 18-cycle operator frame and samples the 10-bit phase of one chosen slot for a programmed number of frames. Samples are buffered in a FIFO and handed to a host-side debug port over a valid/ready handshake. It sits beside the phase generator, taps `o_OP_PHASE`, and never drives the synthesis path.

---
 rtl/ikaopll_phase_capture.sv | 183 ++++++++++++++++++
 tb/tb_ikaopll_phase_capture.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ikaopll_phase_capture.sv
// ikaopll_phase_capture
// Debug reader that sits beside the phase generator and taps its per-slot
// phase output. It follows the 18-cycle operator frame and samples the
// 10-bit phase of one chosen slot once per frame, for a programmed number
// of frames. Each sample is tagged with a 6-bit sequence number, buffered
// in a first-word-fall-through FIFO and handed to a host debug port over
// a valid/ready handshake. Nothing here feeds back into the synthesis path.
//
// Ports
//   i_EMUCLK       emulator master clock (only clock)
//   i_RST          synchronous active-high reset
//   i_phi1_NCEN_n  active-low slot-advance enable, one operator cycle per low clock
//   i_CYCLE_21     last-cycle-of-frame marker, qualified by the enable
//   i_OP_PHASE     phase-generator output for the current cycle
//   i_ARM          one-clock start request, honoured only when idle
//   i_ABORT        one-clock cancel request
//   i_SLOT         cycle index to capture (0..17), latched at arm
//   i_COUNT        number of samples (0 means 256), latched at arm
//   o_DATA         {seq[5:0], phase[9:0]} at the FIFO head, 0 when empty
//   o_VALID        FIFO not empty
//   i_READY        host accepts the head entry
//   o_LEVEL        FIFO occupancy
//   o_BUSY         waiting for the frame start or capturing
//   o_DONE         one-clock pulse after the final sample
//   o_OVERFLOW     sticky: a sample was dropped because the FIFO was full

module ikaopll_phase_capture #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                         i_EMUCLK,
    input  logic                         i_RST,
    input  logic                         i_phi1_NCEN_n,
    input  logic                         i_CYCLE_21,
    input  logic [9:0]                   i_OP_PHASE,
    input  logic                         i_ARM,
    input  logic                         i_ABORT,
    input  logic [4:0]                   i_SLOT,
    input  logic [7:0]                   i_COUNT,
    output logic [15:0]                  o_DATA,
    output logic                         o_VALID,
    input  logic                         i_READY,
    output logic [$clog2(FIFO_DEPTH):0]  o_LEVEL,
    output logic                         o_BUSY,
    output logic                         o_DONE,
    output logic                         o_OVERFLOW
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CAPTURE
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [4:0]    cyc_cnt;
    logic [4:0]    slot_q;
    logic [8:0]    remaining;
    logic [5:0]    seq;
    logic          overflow;
    logic          done;

    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [LW-1:0] level;

    logic          en;
    logic          arm_ok;
    logic          sample;
    logic          full;
    logic          push;
    logic          pop;
    logic          last;

    // Qualified events. Abort suppresses a sample on the same clock, and the
    // full check looks at the level before any same-clock pop.
    always_comb begin
        en     = ~i_phi1_NCEN_n;
        arm_ok = (state == ST_IDLE) & i_ARM & (i_SLOT <= 5'd17);
        sample = (state == ST_CAPTURE) & en & (cyc_cnt == slot_q) & ~i_ABORT;
        full   = (level == FULL_LEVEL);
        push   = sample & ~full;
        pop    = o_VALID & i_READY;
        last   = sample & (remaining == 9'd1);
    end

    // Next-state logic. Abort takes priority in both busy states; the frame
    // marker only moves WAIT to CAPTURE once WAIT has actually been entered.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (arm_ok) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_ABORT) begin
                    state_nxt = ST_IDLE;
                end else if (en & i_CYCLE_21) begin
                    state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (i_ABORT | last) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Frame counter, capture bookkeeping and FIFO pointers. The cycle
    // counter free-runs in every state so the slot position is always known.
    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            state     <= ST_IDLE;
            cyc_cnt   <= 5'd0;
            slot_q    <= 5'd0;
            remaining <= 9'd0;
            seq       <= 6'd0;
            overflow  <= 1'b0;
            done      <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
        end else begin
            state <= state_nxt;
            done  <= last;

            if (en) begin
                cyc_cnt <= i_CYCLE_21 ? 5'd0 : cyc_cnt + 5'd1;
            end

            if (arm_ok) begin
                slot_q    <= i_SLOT;
                remaining <= (i_COUNT == 8'd0) ? 9'd256 : {1'b0, i_COUNT};
                seq       <= 6'd0;
                overflow  <= 1'b0;
            end else if (sample) begin
                seq       <= seq + 6'd1;
                remaining <= remaining - 9'd1;
                if (full) begin
                    overflow <= 1'b1;
                end
            end

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Sample storage carries no reset; the head is masked while empty so
    // stale entries never show on o_DATA.
    always_ff @(posedge i_EMUCLK) begin
        if (push) begin
            mem[wr_ptr] <= {seq, i_OP_PHASE};
        end
    end

    assign o_VALID    = (level != '0);
    assign o_DATA     = o_VALID ? mem[rd_ptr] : 16'd0;
    assign o_LEVEL    = level;
    assign o_BUSY     = (state != ST_IDLE);
    assign o_DONE     = done;
    assign o_OVERFLOW = overflow;

endmodule

// File: tb/tb_ikaopll_phase_capture.sv
// Testbench for ikaopll_phase_capture.
// The driver issues one clock of stimulus at a time and advances a
// frame-level reference model: at arm it schedules the absolute enable
// indices at which samples are due, and every due sample is pushed into a
// scoreboard queue (or counted as dropped). A separate monitor pops the
// queue on every host handshake and compares o_DATA.

module tb_ikaopll_phase_capture;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          i_RST = 1'b1;
    logic          i_phi1_NCEN_n = 1'b1;
    logic          i_CYCLE_21 = 1'b0;
    logic [9:0]    i_OP_PHASE = '0;
    logic          i_ARM = 1'b0;
    logic          i_ABORT = 1'b0;
    logic [4:0]    i_SLOT = '0;
    logic [7:0]    i_COUNT = '0;
    logic          i_READY = 1'b0;
    logic [15:0]   o_DATA;
    logic          o_VALID;
    logic [LW-1:0] o_LEVEL;
    logic          o_BUSY;
    logic          o_DONE;
    logic          o_OVERFLOW;

    always #5 clk = ~clk;

    ikaopll_phase_capture #(.FIFO_DEPTH(DEPTH)) dut (
        .i_EMUCLK      (clk),
        .i_RST         (i_RST),
        .i_phi1_NCEN_n (i_phi1_NCEN_n),
        .i_CYCLE_21    (i_CYCLE_21),
        .i_OP_PHASE    (i_OP_PHASE),
        .i_ARM         (i_ARM),
        .i_ABORT       (i_ABORT),
        .i_SLOT        (i_SLOT),
        .i_COUNT       (i_COUNT),
        .o_DATA        (o_DATA),
        .o_VALID       (o_VALID),
        .i_READY       (i_READY),
        .o_LEVEL       (o_LEVEL),
        .o_BUSY        (o_BUSY),
        .o_DONE        (o_DONE),
        .o_OVERFLOW    (o_OVERFLOW)
    );

    int n_compared = 0;
    int n_failed   = 0;

    logic [15:0] exp_q[$];

    // Frame-level reference model state
    bit m_busy;
    bit m_done;
    bit m_ovf;
    int m_level;
    int en_idx;
    int next_sample;
    int left;
    int m_seq;

    task automatic compare(input string name, input int act, input int exp);
        n_compared++;
        if (act != exp) begin
            n_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkOutput();
        compare("busy",     int'(o_BUSY),     int'(m_busy));
        compare("done",     int'(o_DONE),     int'(m_done));
        compare("overflow", int'(o_OVERFLOW), int'(m_ovf));
        compare("level",    int'(o_LEVEL),    m_level);
        compare("valid",    int'(o_VALID),    int'(m_level != 0));
    endtask

    // One clock: drive inputs, advance the model for the coming edge, then
    // check registered outputs just after that edge.
    task automatic applyStimulus(input bit en, input bit arm, input bit abort,
                                 input int slot, input int count,
                                 input bit ready, input logic [9:0] phase);
        bit sample;
        bit push;
        bit pop;
        int start;
        i_phi1_NCEN_n = ~en;
        i_CYCLE_21    = en ? (en_idx % 18 == 17) : 1'($urandom_range(0, 1));
        i_OP_PHASE    = phase;
        i_ARM         = arm;
        i_ABORT       = abort;
        i_SLOT        = 5'(slot);
        i_COUNT       = 8'(count);
        i_READY       = ready;

        m_done = 0;
        sample = 0;
        push   = 0;
        if (m_busy) begin
            if (abort) begin
                m_busy = 0;
            end else if (en && en_idx == next_sample) begin
                sample = 1;
            end
        end else if (arm && slot <= 17) begin
            // Frame start is the first frame-end enable after the arm clock.
            start = en_idx + (en ? 1 : 0);
            while (start % 18 != 17) start++;
            next_sample = start + 1 + slot;
            left        = (count == 0) ? 256 : count;
            m_seq       = 0;
            m_ovf       = 0;
            m_busy      = 1;
        end
        pop = (m_level > 0) && ready;
        if (sample) begin
            if (m_level < DEPTH) begin
                push = 1;
                exp_q.push_back({6'(m_seq), phase});
            end else begin
                m_ovf = 1;
            end
            m_seq       = (m_seq + 1) % 64;
            left        = left - 1;
            next_sample = next_sample + 18;
            if (left == 0) begin
                m_busy = 0;
                m_done = 1;
            end
        end
        m_level = m_level + int'(push) - int'(pop);
        if (en) en_idx++;

        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic resetDut();
        i_RST         = 1'b1;
        i_phi1_NCEN_n = 1'b1;
        i_ARM         = 1'b0;
        i_ABORT       = 1'b0;
        i_READY       = 1'b0;
        exp_q.delete();
        m_busy  = 0;
        m_done  = 0;
        m_ovf   = 0;
        m_level = 0;
        en_idx  = 0;
        m_seq   = 0;
        @(posedge clk);
        #1;
        compare("reset_data",     int'(o_DATA),     0);
        compare("reset_valid",    int'(o_VALID),    0);
        compare("reset_level",    int'(o_LEVEL),    0);
        compare("reset_busy",     int'(o_BUSY),     0);
        compare("reset_done",     int'(o_DONE),     0);
        compare("reset_overflow", int'(o_OVERFLOW), 0);
        i_RST = 1'b0;
    endtask

    // ready_mode: 0 never, 1 always, 2 random, 3 only on the clock of a due sample
    task automatic runWhileBusy(input int max_cycles, input int ready_mode, input int en_pct);
        int  i;
        bit  en;
        bit  rdy;
        i = 0;
        while (m_busy && i < max_cycles) begin
            en = ($urandom_range(0, 99) < en_pct);
            case (ready_mode)
                0:       rdy = 0;
                1:       rdy = 1;
                2:       rdy = 1'($urandom_range(0, 1));
                default: rdy = en && (en_idx == next_sample);
            endcase
            applyStimulus(en, 0, 0, 0, 0, rdy, 10'($urandom));
            i++;
        end
        compare("busy_timeout", int'(m_busy), 0);
    endtask

    task automatic idleClocks(input int n, input bit ready);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 0, 0, 0, 0, ready, 10'($urandom));
        end
    endtask

    task automatic drain(input int max_cycles);
        int i;
        i = 0;
        while (m_level > 0 && i < max_cycles) begin
            applyStimulus(0, 0, 0, 0, 0, 1, 10'($urandom));
            i++;
        end
        compare("drain_timeout", m_level, 0);
    endtask

    // Scoreboard monitor: a handshake completes at the coming edge whenever
    // valid and ready are both high at the falling edge.
    always @(negedge clk) begin
        logic [15:0] exp;
        if (i_READY === 1'b1 && o_VALID === 1'b1) begin
            if (exp_q.size() == 0) begin
                compare("unexpected_data", int'(o_DATA), -1);
            end else begin
                exp = exp_q.pop_front();
                compare("data", int'(o_DATA), int'(exp));
            end
        end
    end

    initial begin
        int i;
        resetDut();

        // Basic capture, slot 3, four frames
        applyStimulus(1, 1, 0, 3, 4, 1, 10'($urandom));
        runWhileBusy(200, 1, 100);
        idleClocks(3, 1);

        // Overflow: host stalled, six samples into four entries
        applyStimulus(1, 1, 0, 0, 6, 0, 10'($urandom));
        runWhileBusy(300, 0, 100);
        idleClocks(2, 0);

        // Full FIFO with a pop on the sample clock: pop wins, sample dropped
        applyStimulus(1, 1, 0, 2, 1, 0, 10'($urandom));
        runWhileBusy(100, 3, 100);
        drain(20);

        // Slot 17 lands on the frame-end enable of the next frame
        applyStimulus(1, 1, 0, 17, 2, 1, 10'($urandom));
        runWhileBusy(200, 1, 80);
        idleClocks(2, 1);

        // Slot 18 is rejected
        applyStimulus(1, 1, 0, 18, 3, 1, 10'($urandom));
        idleClocks(3, 1);

        // Fill and overflow again so the re-arm below must clear the flag
        applyStimulus(1, 1, 0, 4, 6, 0, 10'($urandom));
        runWhileBusy(300, 0, 100);
        drain(20);

        // Abort after two samples, then re-arm
        applyStimulus(1, 1, 0, 5, 5, 0, 10'($urandom));
        i = 0;
        while (m_busy && m_seq < 2 && i < 200) begin
            applyStimulus(1, 0, 0, 0, 0, 0, 10'($urandom));
            i++;
        end
        compare("abort_setup", m_seq, 2);
        applyStimulus(1, 0, 1, 0, 0, 0, 10'($urandom));
        idleClocks(3, 0);
        applyStimulus(1, 1, 0, 1, 2, 1, 10'($urandom));
        runWhileBusy(200, 1, 100);
        drain(20);

        // Reset with three entries queued mid-capture
        applyStimulus(1, 1, 0, 0, 8, 0, 10'($urandom));
        i = 0;
        while (m_level < 3 && i < 200) begin
            applyStimulus(1, 0, 0, 0, 0, 0, 10'($urandom));
            i++;
        end
        compare("reset_setup", m_level, 3);
        resetDut();
        applyStimulus(1, 1, 0, 6, 2, 1, 10'($urandom));
        runWhileBusy(200, 2, 90);
        drain(20);

        // Count 0 captures 256 samples
        applyStimulus(1, 1, 0, 9, 0, 1, 10'($urandom));
        runWhileBusy(6000, 1, 100);
        drain(20);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            applyStimulus(($urandom_range(0, 99) < 70),
                          ($urandom_range(0, 99) < 4),
                          ($urandom_range(0, 99) < 1),
                          $urandom_range(0, 20),
                          $urandom_range(1, 6),
                          1'($urandom_range(0, 1)),
                          10'($urandom));
        end
        runWhileBusy(1000, 2, 100);
        drain(20);
        compare("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
